// File: rtl/spi_regfile_pkg.sv
// Shared types and constants for the SPI slave register file.
// Flat-vector slice helper is used to unpack per-register reset values.
package spi_regfile_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_e;

  localparam int CMD_WIDTH = 8;
  localparam int RW_BIT    = 7;
  localparam int ADDR_BITS = 7;

  // Largest flat vector the parameter ranges allow (128 regs x 32 bits).
  localparam int FLAT_MAX  = 128 * 32;

  function automatic logic [31:0] reg_slice(input logic [FLAT_MAX-1:0] flat,
                                            input int unsigned idx,
                                            input int unsigned width);
    return 32'(flat >> (idx * width));
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// 2-FF synchronisers for sclk, cs_n and mosi, plus sclk edge detection.
// Edge pulses are one clk_i cycle wide and appear 2 cycles after the pin moves.
module spi_edge_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sclk_i,
  input  logic cs_ni,
  input  logic mosi_i,
  output logic sclk_rise_o,
  output logic sclk_fall_o,
  output logic cs_n_o,
  output logic mosi_o
);

  logic [1:0] sclk_q;
  logic [1:0] cs_q;
  logic [1:0] mosi_q;
  logic       sclk_prev_q;

  // cs_n resets to its inactive level so no phantom transaction follows reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sclk_q      <= 2'b00;
      cs_q        <= 2'b11;
      mosi_q      <= 2'b00;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_q      <= {sclk_q[0], sclk_i};
      cs_q        <= {cs_q[0], cs_ni};
      mosi_q      <= {mosi_q[0], mosi_i};
      sclk_prev_q <= sclk_q[1];
    end
  end

  assign sclk_rise_o = sclk_q[1] & ~sclk_prev_q;
  assign sclk_fall_o = ~sclk_q[1] & sclk_prev_q;
  assign cs_n_o      = cs_q[1];
  assign mosi_o      = mosi_q[1];

endmodule

// File: rtl/spi_regfile.sv
// SPI mode-1 slave register file with burst auto-increment and write strobes.
// Read-back on MISO is built only when SPI_REGFILE_READBACK_EN is defined.
module spi_regfile
  import spi_regfile_pkg::*;
#(
  parameter int unsigned                       NUM_REGS     = 8,
  parameter int unsigned                       REG_WIDTH    = 8,
  parameter logic [NUM_REGS*REG_WIDTH-1:0]     RESET_VALUES = '0
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              enable_i,
  input  logic                              spi_sclk_i,
  input  logic                              spi_mosi_i,
  input  logic                              spi_cs_ni,
  output logic                              spi_miso_o,
  output logic                              spi_miso_oe_o,
  output logic [NUM_REGS*REG_WIDTH-1:0]     regs_o,
  output logic [NUM_REGS-1:0]               wr_strobe_o,
  output logic                              busy_o
);

  localparam int unsigned IN_W = (REG_WIDTH > CMD_WIDTH) ? REG_WIDTH : CMD_WIDTH;
  localparam logic [ADDR_BITS:0]   NREGS_L   = 8'(NUM_REGS);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = 7'(NUM_REGS - 1);

  logic sclk_rise, sclk_fall, cs_n_s, mosi_s;

  spi_edge_sync u_sync (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .sclk_i      (spi_sclk_i),
    .cs_ni       (spi_cs_ni),
    .mosi_i      (spi_mosi_i),
    .sclk_rise_o (sclk_rise),
    .sclk_fall_o (sclk_fall),
    .cs_n_o      (cs_n_s),
    .mosi_o      (mosi_s)
  );

  state_e                 state_q, state_d;
  logic [5:0]             bit_cnt_q, bit_cnt_d;
  logic [IN_W-1:0]        shin_q, shin_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d, addr_inc;
  logic                   rw_q, rw_d;
  logic                   wr_pend_q, wr_pend_d;
  logic [ADDR_BITS-1:0]   wr_addr_q, wr_addr_d;
  logic [REG_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic [REG_WIDTH-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]    wr_strobe_q;
  logic                   addr_ok;
  logic                   frame_done;

  assign addr_ok    = {1'b0, addr_q} < NREGS_L;
  assign frame_done = enable_i && sclk_fall &&
                      (((state_q == CMD)  && (bit_cnt_q == 6'(CMD_WIDTH - 1))) ||
                       ((state_q == DATA) && (bit_cnt_q == 6'(REG_WIDTH - 1))));

  // In-range addresses wrap within the file; out-of-range ones run on to 127.
  always_comb begin
    if (addr_ok) addr_inc = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
    else         addr_inc = addr_q + 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shin_d    = shin_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    wr_pend_d = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    unique case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        if (!cs_n_s && enable_i) state_d = CMD;
      end
      CMD, DATA: begin
        if (enable_i && sclk_fall) begin
          shin_d    = {shin_q[IN_W-2:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (frame_done) begin
            bit_cnt_d = '0;
            if (state_q == CMD) begin
              state_d = DATA;
              rw_d    = shin_d[RW_BIT];
              addr_d  = shin_d[ADDR_BITS-1:0];
            end else begin
              if (!rw_q && addr_ok) begin
                wr_pend_d = 1'b1;
                wr_addr_d = addr_q;
                wr_data_d = shin_d[REG_WIDTH-1:0];
              end
              addr_d = addr_inc;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A frame completing in the same cycle as CS rising still commits above.
    if ((state_q != IDLE) && (cs_n_s || !enable_i)) state_d = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shin_q    <= '0;
      addr_q    <= '0;
      rw_q      <= 1'b0;
      wr_pend_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shin_q    <= shin_d;
      addr_q    <= addr_d;
      rw_q      <= rw_d;
      wr_pend_q <= wr_pend_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NUM_REGS; i++)
        regs_q[i] <= REG_WIDTH'(reg_slice(FLAT_MAX'(RESET_VALUES), i, REG_WIDTH));
      wr_strobe_q <= '0;
    end else begin
      wr_strobe_q <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (wr_pend_q && (wr_addr_q == 7'(i))) begin
          regs_q[i]      <= wr_data_q;
          wr_strobe_q[i] <= 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign regs_o[g*REG_WIDTH +: REG_WIDTH] = regs_q[g];
  end

  assign wr_strobe_o = wr_strobe_q;
  assign busy_o      = (state_q != IDLE);

`ifdef SPI_REGFILE_READBACK_EN
  logic [REG_WIDTH-1:0] mso_sh_q, mso_sh_d;
  logic                 miso_q, miso_d;
  logic [ADDR_BITS-1:0] rd_addr;
  logic [REG_WIDTH-1:0] rd_dat;

  // Command end preloads the start address; data end preloads the next one.
  assign rd_addr = (state_q == CMD) ? {shin_q[ADDR_BITS-2:0], mosi_s} : addr_inc;

  always_comb begin
    rd_dat = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      if (rd_addr == 7'(i)) rd_dat = regs_q[i];
  end

  always_comb begin
    mso_sh_d = mso_sh_q;
    miso_d   = miso_q;
    if (frame_done) begin
      mso_sh_d = rd_dat;
    end else if (enable_i && sclk_rise && (state_q == DATA)) begin
      miso_d   = mso_sh_q[REG_WIDTH-1];
      mso_sh_d = mso_sh_q << 1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mso_sh_q <= '0;
      miso_q   <= 1'b0;
    end else begin
      mso_sh_q <= mso_sh_d;
      miso_q   <= miso_d;
    end
  end

  assign spi_miso_o    = miso_q;
  assign spi_miso_oe_o = (state_q == DATA) && rw_q;
`else
  logic unused_rise;
  assign unused_rise   = sclk_rise;
  assign spi_miso_o    = 1'b0;
  assign spi_miso_oe_o = 1'b0;
`endif

endmodule

// File: tb/tb_spi_regfile.sv
// Directed plus randomized bench for spi_regfile against an array-based register model.
module tb_spi_regfile;

`ifdef SPI_REGFILE_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic        clk, rst_n, enable, sclk, mosi, cs_n;
  logic        miso, miso_oe, busy;
  logic [63:0] regs;
  logic [7:0]  strobe;

  spi_regfile #(
    .NUM_REGS     (8),
    .REG_WIDTH    (8),
    .RESET_VALUES (64'h0706_0504_0302_0100)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .enable_i      (enable),
    .spi_sclk_i    (sclk),
    .spi_mosi_i    (mosi),
    .spi_cs_ni     (cs_n),
    .spi_miso_o    (miso),
    .spi_miso_oe_o (miso_oe),
    .regs_o        (regs),
    .wr_strobe_o   (strobe),
    .busy_o        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  logic [7:0] mdl [8];
  int         exp_str [8];
  int         got_str [8];
  int         long_str = 0;
  logic [7:0] prev_str = '0;
  int         oe_bad;
  logic [7:0] txd [$];
  logic [7:0] rxd [$];
  logic [7:0] exp_rd [$];

  always @(negedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (strobe[i] === 1'b1) begin
        got_str[i]++;
        if (prev_str[i] === 1'b1) long_str++;
      end
    end
    prev_str = strobe;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic half();
    repeat (8) @(negedge clk);
  endtask

  task automatic xfer_bits(input logic [7:0] v, input int n, input logic exp_oe,
                           output logic [7:0] rx);
    rx = '0;
    for (int b = n - 1; b >= 0; b--) begin
      sclk = 1'b1;
      mosi = v[b];
      half();
      rx = {rx[6:0], miso};
      if (miso_oe !== exp_oe) oe_bad++;
      sclk = 1'b0;
      half();
    end
  endtask

  // Register-level model: walk the burst address by address.
  task automatic model(input logic [7:0] cmd);
    int a;
    a = int'(cmd[6:0]);
    exp_rd = {};
    foreach (txd[k]) begin
      if (cmd[7]) begin
        exp_rd.push_back(a < 8 ? mdl[a] : 8'h00);
      end else if (a < 8) begin
        mdl[a] = txd[k];
        exp_str[a]++;
      end
      a = (a < 8) ? (a + 1) % 8 : (a + 1) % 128;
    end
  endtask

  task automatic compare_state(input string tag);
    logic [63:0] ef;
    for (int i = 0; i < 8; i++) ef[i*8 +: 8] = mdl[i];
    chk({tag, "_regs"}, regs, ef);
    for (int i = 0; i < 8; i++) chk({tag, "_strobe_cnt"}, 64'(got_str[i]), 64'(exp_str[i]));
    chk({tag, "_strobe_width"}, 64'(long_str), 64'd0);
  endtask

  task automatic txn(input string tag, input logic [7:0] cmd);
    logic [7:0] r;
    logic       doe;
    doe    = cmd[7] & RB;
    oe_bad = 0;
    rxd    = {};
    cs_n   = 1'b0;
    half();
    xfer_bits(cmd, 8, 1'b0, r);
    foreach (txd[k]) begin
      xfer_bits(txd[k], 8, doe, r);
      rxd.push_back(r);
    end
    half();
    cs_n = 1'b1;
    repeat (12) @(negedge clk);
    model(cmd);
    compare_state(tag);
    chk({tag, "_oe"}, 64'(oe_bad), 64'd0);
    if (cmd[7])
      foreach (rxd[k]) chk({tag, "_miso"}, rxd[k], RB ? exp_rd[k] : 8'h00);
  endtask

  initial begin
    logic [7:0] r;
    logic [7:0] cmd;
    int         nfr;

    for (int i = 0; i < 8; i++) begin
      mdl[i]     = 8'(i);
      exp_str[i] = 0;
      got_str[i] = 0;
    end
    rst_n  = 1'b0;
    enable = 1'b1;
    sclk   = 1'b0;
    mosi   = 1'b0;
    cs_n   = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    chk("reset_regs", regs, 64'h0706_0504_0302_0100);
    chk("reset_strobe", strobe, 8'h00);
    chk("reset_busy", busy, 1'b0);
    chk("reset_miso", miso, 1'b0);
    chk("reset_oe", miso_oe, 1'b0);

    // Single write with exact update latency after the last falling edge.
    oe_bad = 0;
    cs_n   = 1'b0;
    half();
    xfer_bits(8'h02, 8, 1'b0, r);
    xfer_bits(8'h52, 7, 1'b0, r);
    sclk = 1'b1;
    mosi = 1'b1;
    half();
    sclk = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("lat_before", regs[23:16], 8'h02);
    @(posedge clk);
    #1 chk("lat_value", regs[23:16], 8'hA5);
    chk("lat_strobe", strobe, 8'b0000_0100);
    @(posedge clk);
    #1 chk("lat_strobe_clear", strobe, 8'h00);
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (12) @(negedge clk);
    txd = {8'hA5};
    model(8'h02);
    compare_state("single");

    txd = {8'h11, 8'h22, 8'h33};
    txn("burst_wrap", 8'h06);

    txd = {8'h5A};
    txn("wr_reg3", 8'h03);
    txd = {8'(8'h3C), 8'(8'hC3)};
    txn("read_reg3", 8'h83);

    // CS abort mid data frame.
    cs_n = 1'b0;
    half();
    xfer_bits(8'h01, 8, 1'b0, r);
    xfer_bits(8'h1F, 5, 1'b0, r);
    chk("abort_busy_hi", busy, 1'b1);
    cs_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_busy_lo", busy, 1'b0);
    compare_state("abort");
    txd = {8'h77};
    txn("after_abort", 8'h01);

    txd = {8'hC3};
    txn("out_of_range", 8'h7F);

    // enable_i low: a full write frame must be ignored.
    enable = 1'b0;
    cs_n   = 1'b0;
    half();
    chk("dis_busy", busy, 1'b0);
    xfer_bits(8'h00, 8, 1'b0, r);
    xfer_bits(8'hEE, 8, 1'b0, r);
    chk("dis_busy_end", busy, 1'b0);
    half();
    cs_n = 1'b1;
    repeat (12) @(negedge clk);
    compare_state("disabled");
    enable = 1'b1;
    repeat (4) @(negedge clk);

    for (int t = 0; t < 10; t++) begin
      cmd[7]   = 1'($urandom_range(0, 1));
      cmd[6:0] = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(124, 127))
                                             : 7'($urandom_range(0, 9));
      nfr = $urandom_range(1, 4);
      txd = {};
      for (int k = 0; k < nfr; k++) txd.push_back(8'($urandom));
      txn("random", cmd);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
